// File: rtl/mux_reg_pkg.sv
// rtl/mux_reg_pkg.sv - mode encoding shared by the mux_reg_pipe slice
//
// Purpose: operation codes applied at stage 0 of mux_reg_pipe.
//   MODE_LOAD  capture the selected word
//   MODE_HOLD  keep stage-0 data, inject a bubble, let downstream drain
//   MODE_CLEAR flush every stage (ignores en)
//   MODE_INV   capture the bitwise inverse of the selected word
package mux_reg_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LOAD  = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_CLEAR = 2'd2,
    MODE_INV   = 2'd3
  } mode_e;

endpackage

// File: rtl/mux_reg_stage.sv
// rtl/mux_reg_stage.sv - one pipeline stage carrying data, valid and err
//
// Purpose: single register slice of mux_reg_pipe.
// Ports:
//   clk      clock, all updates on rising edge
//   rst      synchronous active-high reset, zeroes the stage
//   en       advance enable; low holds the stage
//   clr      synchronous flush, zeroes the stage regardless of en
//   data_in  incoming data word
//   vld_in   incoming valid flag
//   err_in   incoming out-of-range flag
//   data     registered data word
//   vld      registered valid flag
//   err      registered out-of-range flag
module mux_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_in,
  input  logic             vld_in,
  input  logic             err_in,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             err
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      data <= '0;
      vld  <= 1'b0;
      err  <= 1'b0;
    end else if (en) begin
      data <= data_in;
      vld  <= vld_in;
      err  <= err_in;
    end
  end

endmodule

// File: rtl/mux_reg_pipe.sv
// rtl/mux_reg_pipe.sv - selectable, optionally inverted, fixed-latency register pipe
//
// Purpose: picks one of NUM_IN words, optionally inverts it, and carries it
// with a valid flag through DEPTH register stages.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset, overrides everything
//   en       advance enable; low freezes all stages except on CLEAR
//   mode     LOAD=0, HOLD=1, CLEAR=2, INV=3
//   sel      input select
//   d        packed inputs, input i at d[i*WIDTH +: WIDTH]
//   vld_in   input word valid
//   q        last-stage data
//   vld_out  last-stage valid
//   sel_err  last-stage flag: word was captured with sel >= NUM_IN
module mux_reg_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [1:0]              mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] d,
  input  logic                    vld_in,
  output logic [WIDTH-1:0]        q,
  output logic                    vld_out,
  output logic                    sel_err
);

  import mux_reg_pkg::*;

  // One extra bit so NUM_IN itself is representable in the compare.
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  mode_e            op;
  logic             sel_oor;
  logic             clr;
  logic [WIDTH-1:0] word;
  logic [WIDTH-1:0] s0_data;
  logic             s0_vld;
  logic             s0_err;

  logic [WIDTH-1:0] st_data [DEPTH];
  logic             st_vld  [DEPTH];
  logic             st_err  [DEPTH];

  assign op      = mode_e'(mode);
  assign clr     = (op == MODE_CLEAR);
  assign sel_oor = ({1'b0, sel} >= NUM_IN_W);

  // Out-of-range selects fall back to input 0; the err flag marks the token.
  always_comb begin
    word = d[WIDTH-1:0];
    for (int i = 1; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        word = d[i*WIDTH +: WIDTH];
      end
    end
  end

  // HOLD recirculates stage-0 data but injects a bubble so downstream drains.
  always_comb begin
    s0_data = word;
    s0_vld  = vld_in;
    s0_err  = sel_oor;
    case (op)
      MODE_INV: begin
        s0_data = ~word;
      end
      MODE_HOLD: begin
        s0_data = st_data[0];
        s0_vld  = 1'b0;
        s0_err  = 1'b0;
      end
      default: begin
      end
    endcase
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic             in_vld;
    logic             in_err;

    if (g == 0) begin : g_first
      assign in_data = s0_data;
      assign in_vld  = s0_vld;
      assign in_err  = s0_err;
    end else begin : g_next
      assign in_data = st_data[g-1];
      assign in_vld  = st_vld[g-1];
      assign in_err  = st_err[g-1];
    end

    mux_reg_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .clr     (clr),
      .data_in (in_data),
      .vld_in  (in_vld),
      .err_in  (in_err),
      .data    (st_data[g]),
      .vld     (st_vld[g]),
      .err     (st_err[g])
    );
  end

  assign q       = st_data[DEPTH-1];
  assign vld_out = st_vld[DEPTH-1];
  assign sel_err = st_err[DEPTH-1];

endmodule

// File: tb/tb_mux_reg_pipe.sv
// tb/tb_mux_reg_pipe.sv - self-checking bench for mux_reg_pipe
//
// Three instances: (NUM_IN=4, DEPTH=2), (NUM_IN=3, DEPTH=3), (NUM_IN=5, DEPTH=1).
module tb_mux_reg_pipe;

  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] CLR  = 2'd2;
  localparam logic [1:0] INV  = 2'd3;

  typedef struct {
    logic [7:0] data;
    logic       vld;
    logic       err;
    logic       known;
  } token_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic        vld_in;
  logic [31:0] d4;
  logic [1:0]  sel4;
  logic [23:0] d3;
  logic [1:0]  sel3;
  logic [39:0] d5;
  logic [2:0]  sel5;

  logic [7:0]  qo [3];
  logic        vo [3];
  logic        eo [3];

  int          checks = 0;
  int          passed = 0;

  // Reference: per instance, a queue of tokens; index 0 is newest, last is visible.
  token_t      mq  [3][$];
  int          dep [3];

  always #5 clk = ~clk;

  mux_reg_pipe #(.WIDTH(8), .NUM_IN(4), .DEPTH(2)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel4), .d(d4),
    .vld_in(vld_in), .q(qo[0]), .vld_out(vo[0]), .sel_err(eo[0])
  );

  mux_reg_pipe #(.WIDTH(8), .NUM_IN(3), .DEPTH(3)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel3), .d(d3),
    .vld_in(vld_in), .q(qo[1]), .vld_out(vo[1]), .sel_err(eo[1])
  );

  mux_reg_pipe #(.WIDTH(8), .NUM_IN(5), .DEPTH(1)) u_dut5 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel5), .d(d5),
    .vld_in(vld_in), .q(qo[2]), .vld_out(vo[2]), .sel_err(eo[2])
  );

  function automatic logic [7:0] pick(logic [63:0] dv, int s, int n);
    if (s < n) return dv[s*8 +: 8];
    return dv[7:0];
  endfunction

  function automatic token_t mk(logic [1:0] m, logic v, logic [7:0] w, logic o, token_t front);
    token_t t;
    case (m)
      LOAD:    t = '{w, v, o, v};
      INV:     t = '{~w, v, o, v};
      default: t = '{front.data, 1'b0, 1'b0, front.known};
    endcase
    return t;
  endfunction

  task automatic model_flush();
    token_t z;
    z = '{8'h00, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      for (int k = 0; k < dep[i]; k++) mq[i].push_back(z);
    end
  endtask

  // Advance one clock edge, step the reference, then settle past the edge.
  task automatic tick();
    logic [7:0] w [3];
    logic       o [3];
    token_t     t;
    @(posedge clk);
    w[0] = pick(64'(d4), int'(sel4), 4); o[0] = (int'(sel4) >= 4);
    w[1] = pick(64'(d3), int'(sel3), 3); o[1] = (int'(sel3) >= 3);
    w[2] = pick(64'(d5), int'(sel5), 5); o[2] = (int'(sel5) >= 5);
    if (rst || mode == CLR) begin
      model_flush();
    end else if (en) begin
      for (int i = 0; i < 3; i++) begin
        t = mk(mode, vld_in, w[i], o[i], mq[i][0]);
        mq[i].push_front(t);
        void'(mq[i].pop_back());
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = LOAD; vld_in = 1'b1;
    d4 = '1; d3 = '1; d5 = '1; sel4 = 2'd1; sel3 = 2'd3; sel5 = 3'd7;
    for (int e = 0; e < 2; e++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++; if (qo[i] !== 8'h00) $display("FAIL reset_q[%0d]: got %h want 00", i, qo[i]); else passed++;
        checks++; if (vo[i] !== 1'b0) $display("FAIL reset_vld[%0d]: got %b want 0", i, vo[i]); else passed++;
        checks++; if (eo[i] !== 1'b0) $display("FAIL reset_err[%0d]: got %b want 0", i, eo[i]); else passed++;
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_load_sweep();
    logic [7:0] exp_q [4];
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    d4 = {8'h44, 8'h33, 8'h22, 8'h11}; en = 1'b1; mode = LOAD;
    for (int e = 1; e <= 6; e++) begin
      vld_in = (e <= 4);
      sel4   = (e <= 4) ? 2'(e - 1) : 2'd0;
      tick();
      if (e >= 2 && e <= 5) begin
        checks++; if (vo[0] !== 1'b1) $display("FAIL sweep_vld e%0d: got %b want 1", e, vo[0]); else passed++;
        checks++; if (qo[0] !== exp_q[e-2]) $display("FAIL sweep_q e%0d: got %h want %h", e, qo[0], exp_q[e-2]); else passed++;
      end else begin
        checks++; if (vo[0] !== 1'b0) $display("FAIL sweep_idle_vld e%0d: got %b want 0", e, vo[0]); else passed++;
      end
      checks++; if (eo[0] !== 1'b0) $display("FAIL sweep_err e%0d: got %b want 0", e, eo[0]); else passed++;
    end
  endtask

  task automatic test_inv_hold();
    logic [1:0] m_t   [4];
    logic       v_t   [4];
    logic [7:0] q_t   [4];
    m_t = '{LOAD, INV, HOLD, HOLD};
    v_t = '{1'b0, 1'b1, 1'b1, 1'b0};
    q_t = '{8'h00, 8'h22, 8'hCC, 8'hCC};
    d4 = {8'h44, 8'h33, 8'h22, 8'h11}; en = 1'b1; vld_in = 1'b1;
    for (int e = 0; e < 4; e++) begin
      mode = m_t[e];
      sel4 = (e == 0) ? 2'd1 : 2'd2;
      tick();
      checks++; if (vo[0] !== v_t[e]) $display("FAIL invhold_vld e%0d: got %b want %b", e, vo[0], v_t[e]); else passed++;
      if (e > 0) begin
        checks++; if (qo[0] !== q_t[e]) $display("FAIL invhold_q e%0d: got %h want %h", e, qo[0], q_t[e]); else passed++;
      end
    end
  endtask

  task automatic test_stall();
    logic       en_t [9];
    logic [7:0] dn_t [9];
    logic       vi_t [9];
    logic       ev_t [9];
    logic [7:0] eq_t [9];
    en_t = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    dn_t = '{8'hA0, 8'hA1, 8'hFF, 8'hFF, 8'hFF, 8'hA2, 8'hA3, 8'h00, 8'h00};
    vi_t = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    ev_t = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
    eq_t = '{8'h00, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    mode = LOAD; sel4 = 2'd0;
    for (int e = 0; e < 9; e++) begin
      en = en_t[e]; vld_in = vi_t[e]; d4 = {24'hFFFFFF, dn_t[e]};
      tick();
      checks++; if (vo[0] !== ev_t[e]) $display("FAIL stall_vld e%0d: got %b want %b", e, vo[0], ev_t[e]); else passed++;
      if (ev_t[e]) begin
        checks++; if (qo[0] !== eq_t[e]) $display("FAIL stall_q e%0d: got %h want %h", e, qo[0], eq_t[e]); else passed++;
      end
    end
    en = 1'b1;
  endtask

  task automatic test_flush();
    mode = LOAD; sel4 = 2'd0; en = 1'b1; vld_in = 1'b1;
    d4 = 32'h000000B0; tick();
    d4 = 32'h000000B1; tick();
    checks++; if (qo[0] !== 8'hB0 || vo[0] !== 1'b1) $display("FAIL flush_pre: got %h/%b want b0/1", qo[0], vo[0]); else passed++;
    mode = CLR; en = 1'b0; tick();
    checks++; if (qo[0] !== 8'h00) $display("FAIL flush_q: got %h want 00", qo[0]); else passed++;
    checks++; if (vo[0] !== 1'b0) $display("FAIL flush_vld: got %b want 0", vo[0]); else passed++;
    mode = LOAD; en = 1'b1; vld_in = 1'b0; d4 = 32'h0000005F;
    for (int e = 0; e < 3; e++) begin
      tick();
      checks++; if (vo[0] !== 1'b0) $display("FAIL flush_after_vld e%0d: got %b want 0", e, vo[0]); else passed++;
      if (e == 0) begin
        checks++; if (qo[0] !== 8'h00) $display("FAIL flush_after_q: got %h want 00", qo[0]); else passed++;
      end
    end
  endtask

  task automatic test_out_of_range();
    rst = 1'b1; tick(); rst = 1'b0;
    en = 1'b1; mode = LOAD; vld_in = 1'b1;
    d3 = {8'h77, 8'h66, 8'h5A};
    d5 = {8'h99, 8'h88, 8'h77, 8'h66, 8'h3C};
    sel3 = 2'd3; sel5 = 3'd6; tick();
    checks++; if (qo[2] !== 8'h3C || vo[2] !== 1'b1 || eo[2] !== 1'b1)
      $display("FAIL oor_d1_first: got %h/%b/%b want 3c/1/1", qo[2], vo[2], eo[2]); else passed++;
    sel3 = 2'd2; sel5 = 3'd4; tick();
    checks++; if (qo[2] !== 8'h99 || vo[2] !== 1'b1 || eo[2] !== 1'b0)
      $display("FAIL oor_d1_second: got %h/%b/%b want 99/1/0", qo[2], vo[2], eo[2]); else passed++;
    vld_in = 1'b0; tick();
    checks++; if (qo[1] !== 8'h5A || vo[1] !== 1'b1 || eo[1] !== 1'b1)
      $display("FAIL oor_first: got %h/%b/%b want 5a/1/1", qo[1], vo[1], eo[1]); else passed++;
    tick();
    checks++; if (qo[1] !== 8'h77 || vo[1] !== 1'b1 || eo[1] !== 1'b0)
      $display("FAIL oor_second: got %h/%b/%b want 77/1/0", qo[1], vo[1], eo[1]); else passed++;
  endtask

  task automatic test_random();
    token_t ex;
    int     r;
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 49) == 0);
      en     = ($urandom_range(0, 9) != 0);
      r      = $urandom_range(0, 19);
      mode   = (r == 0) ? CLR : (r < 5) ? HOLD : (r < 10) ? INV : LOAD;
      vld_in = 1'($urandom_range(0, 1));
      d4     = $urandom();
      d3     = 24'($urandom());
      d5     = 40'({$urandom(), $urandom()});
      sel4   = 2'($urandom_range(0, 3));
      sel3   = 2'($urandom_range(0, 3));
      sel5   = 3'($urandom_range(0, 7));
      tick();
      for (int i = 0; i < 3; i++) begin
        ex = mq[i][dep[i]-1];
        checks++; if (vo[i] !== ex.vld) $display("FAIL rand_vld[%0d] n%0d: got %b want %b", i, n, vo[i], ex.vld); else passed++;
        checks++; if (eo[i] !== ex.err) $display("FAIL rand_err[%0d] n%0d: got %b want %b", i, n, eo[i], ex.err); else passed++;
        if (ex.vld || ex.known) begin
          checks++; if (qo[i] !== ex.data) $display("FAIL rand_q[%0d] n%0d: got %h want %h", i, n, qo[i], ex.data); else passed++;
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    dep[0] = 2; dep[1] = 3; dep[2] = 1;
    model_flush();
    rst = 1'b0; en = 1'b0; mode = LOAD; vld_in = 1'b0;
    d4 = '0; d3 = '0; d5 = '0; sel4 = '0; sel3 = '0; sel5 = '0;
    test_reset();
    test_load_sweep();
    test_inv_hold();
    test_stall();
    test_flush();
    test_out_of_range();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
